// File: rtl/ntt_bank_pkg.sv
// Shared constants and types for the NTT bank read path.
// Optional BANK_READ_PERF_EN adds a stall counter on the reader.
package ntt_bank_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    addr_t base;
    addr_t stride;
    cnt_t  count;
  } cmd_t;

endpackage

// File: rtl/bank_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs the bank read latency
// so the reader can keep issuing under backpressure.
module bank_skid_fifo
  import ntt_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [1:0]        cnt
);

  data_t mem [2];
  logic  wp;
  logic  rp;
  logic  do_push;
  logic  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bank_stream_reader.sv
// Strided read master for one 128x12 NTT bank feeding a valid/ready stream.
// Define BANK_READ_PERF_EN to add the stall_cycles output.
module bank_stream_reader
  import ntt_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_a2,
  output logic              mem_iren,
  output logic              mem_ien,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef BANK_READ_PERF_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  state_t     state;
  cmd_t       cmd;
  addr_t      addr;
  addr_t      a2_hold;
  cnt_t       issued;
  logic       inflight;
  logic       pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic [1:0] fifo_cnt;
  logic [2:0] occ;
  logic       room;

  assign pop       = out_valid & out_ready;
  assign out_valid = ~fifo_empty;
  assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight};
  // A same-cycle pop frees a slot for the read being issued now.
  assign room      = (occ < 3'd2) || (pop && (occ < 3'd3));

  assign mem_iren = (state == RUN) && (issued < cmd.count)
                    && room && !(fifo_full && !pop);
  assign mem_ien  = mem_iren;
  assign mem_a2   = mem_iren ? addr : a2_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd      <= '0;
      addr     <= '0;
      a2_hold  <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= mem_iren;
      if (mem_iren) begin
        a2_hold <= addr;
        addr    <= addr + cmd.stride;
        issued  <= issued + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              cmd    <= '{base_addr, stride, count};
              addr   <= base_addr;
              issued <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (mem_iren && (issued + 1'b1 == cmd.count))
            state <= DRAIN;
        end
        DRAIN: begin
          if (!inflight && ((fifo_cnt == 2'd0) ||
              ((fifo_cnt == 2'd1) && pop))) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bank_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (mem_q),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

`ifdef BANK_READ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready &&
                 (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
